// File: rtl/dw_tap_sequencer_pkg.sv
// dw_pkg: sequencer state encoding, lane geometry and the lane-slice helper.
package dw_pkg;
   localparam int DW_LANES     = 4;
   localparam int DW_DATA_W    = 8;
   localparam int DW_TAP_IDX_W = 4;
   typedef enum logic [2:0] {IDLE, CLEAR, TAP, FLUSH, DONE} dw_seq_state_t;
   function automatic logic [DW_DATA_W-1:0] dw_lane(input logic [DW_LANES*DW_DATA_W-1:0] w, input int i);
      return w[DW_LANES*DW_DATA_W-1-DW_DATA_W*i -: DW_DATA_W];
   endfunction
endpackage

// File: rtl/dw_tap_sequencer_if.sv
// dw_tap_sequencer_if: job control, IFM tap stream, weight-buffer port and cluster feed.
// stall_cycles exists only when DW_STALL_CNT_EN is defined.
interface dw_tap_sequencer_if;
   import dw_pkg::*;
   logic start;
   logic [15:0] num_pixels;
   logic ifm_valid, ifm_ready;
   logic [DW_LANES*DW_DATA_W-1:0] ifm_data, wgt_data, IFM;
   logic [DW_TAP_IDX_W-1:0] wgt_addr;
   logic [DW_DATA_W-1:0] Weight_0, Weight_1, Weight_2, Weight_3;
   logic PE_reset, PE_finish, ofm_valid, busy, done;
`ifdef DW_STALL_CNT_EN
   logic [31:0] stall_cycles;
`endif
   modport master (
      input start, num_pixels, ifm_valid, ifm_data, wgt_data,
`ifdef DW_STALL_CNT_EN
      output stall_cycles,
`endif
      output ifm_ready, wgt_addr, IFM, Weight_0, Weight_1, Weight_2, Weight_3,
      output PE_reset, PE_finish, ofm_valid, busy, done
   );
   modport slave (
      output start, num_pixels, ifm_valid, ifm_data, wgt_data,
`ifdef DW_STALL_CNT_EN
      input stall_cycles,
`endif
      input ifm_ready, wgt_addr, IFM, Weight_0, Weight_1, Weight_2, Weight_3,
      input PE_reset, PE_finish, ofm_valid, busy, done
   );
endinterface

// File: rtl/dw_tap_sequencer_align.sv
// dw_tap_align: one-stage bank presenting an accepted tap, its weights and PE_finish together,
// plus the one-cycle PE_finish -> ofm_valid delay.
module dw_tap_align
   import dw_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic fire,
   input  logic last,
   input  logic [DW_LANES*DW_DATA_W-1:0] ifm_data,
   input  logic [DW_LANES*DW_DATA_W-1:0] wgt_data,
   output logic [DW_LANES*DW_DATA_W-1:0] ifm,
   output logic [DW_DATA_W-1:0] weight [DW_LANES],
   output logic pe_finish,
   output logic ofm_valid
);
   logic v;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         ifm <= '0;
         v <= 1'b0;
         pe_finish <= 1'b0;
         ofm_valid <= 1'b0;
      end else begin
         ifm <= fire ? ifm_data : '0;
         v <= fire;
         pe_finish <= fire && last;
         ofm_valid <= pe_finish;
      end
   // the buffer's own read register already lines wgt_data up with ifm; v masks bubbles
   for (genvar i = 0; i < DW_LANES; i++) begin : g_lane
      assign weight[i] = v ? dw_lane(wgt_data, i) : '0;
   end
endmodule

// File: rtl/dw_tap_sequencer.sv
// dw_tap_sequencer: job FSM sequencing KERNEL_TAPS taps per pixel into the depthwise PE cluster.
// Define DW_STALL_CNT_EN to add the stall_cycles counter.
module dw_tap_sequencer
   import dw_pkg::*;
#(
   parameter int KERNEL_TAPS = 9
) (
   input logic clk,
   input logic reset,
   dw_tap_sequencer_if.master bus
);
   dw_seq_state_t state, state_nx;
   logic [DW_TAP_IDX_W-1:0] tap_cnt;
   logic [15:0] pix_cnt, num_lat;
   logic fire, last_tap, last_pix, pe_reset, pe_finish, ofm_valid;
   logic [DW_LANES*DW_DATA_W-1:0] ifm;
   logic [DW_DATA_W-1:0] weight [DW_LANES];
   assign fire     = state == TAP && bus.ifm_valid;
   assign last_tap = tap_cnt == DW_TAP_IDX_W'(KERNEL_TAPS - 1);
   assign last_pix = pix_cnt == num_lat - 16'd1;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state <= IDLE;
         tap_cnt <= '0;
         pix_cnt <= '0;
         num_lat <= '0;
         pe_reset <= 1'b0;
      end else begin
         state <= state_nx;
         pe_reset <= state == CLEAR;
         if (state == IDLE && bus.start) begin
            num_lat <= bus.num_pixels;
            pix_cnt <= '0;
         end
         if (state == CLEAR)
            tap_cnt <= '0;
         else if (fire) begin
            tap_cnt <= last_tap ? '0 : tap_cnt + 1'b1;
            if (last_tap) pix_cnt <= pix_cnt + 16'd1;
         end
      end
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = !bus.start ? IDLE : (bus.num_pixels == '0 ? DONE : CLEAR);
         CLEAR:   state_nx = TAP;
         TAP:     state_nx = !(fire && last_tap) ? TAP : (last_pix ? FLUSH : CLEAR);
         FLUSH:   state_nx = ofm_valid ? DONE : FLUSH;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end
   dw_tap_align u_align (
      .clk       (clk),
      .reset     (reset),
      .fire      (fire),
      .last      (last_tap),
      .ifm_data  (bus.ifm_data),
      .wgt_data  (bus.wgt_data),
      .ifm       (ifm),
      .weight    (weight),
      .pe_finish (pe_finish),
      .ofm_valid (ofm_valid)
   );
   assign bus.ifm_ready = state == TAP;
   assign bus.busy      = state == CLEAR || state == TAP || state == FLUSH;
   assign bus.done      = state == DONE;
   assign bus.wgt_addr  = tap_cnt;
   assign bus.IFM       = ifm;
   assign bus.Weight_0  = weight[0];
   assign bus.Weight_1  = weight[1];
   assign bus.Weight_2  = weight[2];
   assign bus.Weight_3  = weight[3];
   assign bus.PE_reset  = pe_reset;
   assign bus.PE_finish = pe_finish;
   assign bus.ofm_valid = ofm_valid;
`ifdef DW_STALL_CNT_EN
   logic [31:0] stall_cnt;
   always_ff @(posedge clk or posedge reset)
      if (reset)
         stall_cnt <= '0;
      else if (state == IDLE && bus.start)
         stall_cnt <= '0;
      else if (state == TAP && !bus.ifm_valid && !(&stall_cnt))
         stall_cnt <= stall_cnt + 32'd1;
   assign bus.stall_cycles = stall_cnt;
`endif
endmodule
